vga_sprite_render: RTL and testbench

Pixel renderer that sits directly downstream of the 640x480 VGA timing generator. It consumes the generator's horizontal/vertical counters and syncs and produces registered 3-bit RGB plus delay-matched syncs for the connector. Software controls it over a Wishbone slave port: a background colour and one rectangular player sprite. Register updates take effect only at the start of vertical blanking, so no frame ever tears.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/wb_vga_regs.sv | 113 +++++++++++
 rtl/vga_sprite_render.sv | 115 +++++++++++
 tb/tb_vga_sprite_render.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA sprite renderer.
//   - H_ACTIVE_DEF / V_ACTIVE_DEF : default visible area (640x480)
//   - REG_* : Wishbone register word indices
//   - 3-bit colour constants, ordered {r,g,b}
//   - bank_t : one register bank (pending or active)
//   - sat_size() : clamps a sprite dimension to the configured maximum
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_SPR_X    = 3'd1;
    localparam logic [2:0] REG_SPR_Y    = 3'd2;
    localparam logic [2:0] REG_SPR_ATTR = 3'd3;
    localparam logic [2:0] REG_FRAMES   = 3'd4;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef struct packed {
        logic [2:0] spr_col;
        logic [6:0] spr_h;
        logic [6:0] spr_w;
        logic [9:0] spr_y;
        logic [9:0] spr_x;
        logic [2:0] bg;
        logic       spr_en;
    } bank_t;

    function automatic logic [6:0] sat_size(input logic [6:0] val, input logic [6:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/wb_vga_regs.sv
// wb_vga_regs: Wishbone classic slave holding the renderer's registers.
//   clk, rst                 : clock, synchronous active-high reset
//   pix_en, hcount, vcount   : timing inputs, used to find the bank-load point
//   wb_*                     : Wishbone slave port (word select wb_adr_i[4:2])
//   active                   : active bank, stable for the whole visible frame
//   frame_irq                : one-clk pulse following each bank load
// Writes go to the pending bank; pending is copied to active once per frame
// on the pix_en tick at (hcount==0, vcount==V_ACTIVE).
module wb_vga_regs
    import vga_pkg::*;
#(
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int SPR_W_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output bank_t       active,
    output logic        frame_irq
);

    logic        ack_reg, ack_next;
    logic [31:0] dat_o_reg, rd_data;
    bank_t       pend_reg, pend_next, act_reg;
    logic [15:0] frames_reg;
    logic        irq_reg;
    logic        req, wr_commit, load;
    logic [2:0]  idx;

    // Byte-lane bits and data bits with no register field behind them.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:19], wb_dat_i[15]};

    assign req       = wb_cyc_i & wb_stb_i;
    assign idx       = wb_adr_i[4:2];
    // Ack is suppressed the cycle after an ack, so a held strobe gets at
    // most one ack every two clocks.
    assign ack_next  = req & ~ack_reg;
    // Write lands at the end of the ack cycle; a strobe dropped during the
    // ack cycle therefore leaves the registers untouched.
    assign wr_commit = ack_reg & req & wb_we_i;
    assign load      = pix_en && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

    always_comb begin
        rd_data = 32'd0;
        case (idx)
            REG_CTRL:     rd_data = {28'd0, pend_reg.bg, pend_reg.spr_en};
            REG_SPR_X:    rd_data = {22'd0, pend_reg.spr_x};
            REG_SPR_Y:    rd_data = {22'd0, pend_reg.spr_y};
            REG_SPR_ATTR: rd_data = {13'd0, pend_reg.spr_col, 1'b0, pend_reg.spr_h,
                                     1'b0, pend_reg.spr_w};
            REG_FRAMES:   rd_data = {16'd0, frames_reg};
            default:      rd_data = 32'd0;
        endcase
    end

    always_comb begin
        pend_next = pend_reg;
        if (wr_commit) begin
            case (idx)
                REG_CTRL: begin
                    pend_next.spr_en = wb_dat_i[0];
                    pend_next.bg     = wb_dat_i[3:1];
                end
                REG_SPR_X: pend_next.spr_x = wb_dat_i[9:0];
                REG_SPR_Y: pend_next.spr_y = wb_dat_i[9:0];
                REG_SPR_ATTR: begin
                    pend_next.spr_w   = sat_size(wb_dat_i[6:0], 7'(SPR_W_MAX));
                    pend_next.spr_h   = sat_size(wb_dat_i[14:8], 7'(SPR_W_MAX));
                    pend_next.spr_col = wb_dat_i[18:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg    <= 1'b0;
            dat_o_reg  <= 32'd0;
            pend_reg   <= '0;
            act_reg    <= '0;
            frames_reg <= 16'd0;
            irq_reg    <= 1'b0;
        end else begin
            ack_reg   <= ack_next;
            dat_o_reg <= ack_next ? rd_data : 32'd0;
            pend_reg  <= pend_next;
            // Active copies the pre-write pending value, so a write that
            // commits on the load edge waits for the following frame.
            if (load) begin
                act_reg    <= pend_reg;
                frames_reg <= frames_reg + 16'd1;
            end
            irq_reg <= load;
        end
    end

    assign wb_ack_o  = ack_reg;
    assign wb_dat_o  = dat_o_reg;
    assign active    = act_reg;
    assign frame_irq = irq_reg;

endmodule

// File: rtl/vga_sprite_render.sv
// vga_sprite_render: background + single rectangular sprite pixel renderer.
//   clk, rst               : clock, synchronous active-high reset
//   pix_en, hcount, vcount : pixel tick and counters from the timing generator
//   hsync_in, vsync_in     : active-low syncs from the timing generator
//   wb_*                   : Wishbone slave port to the register block
//   red, green, blue       : registered pixel colour
//   hsync_out, vsync_out   : syncs delayed one pix_en to match RGB
//   frame_irq              : pulse at each shadow-register load
// Optional macro VGA_RENDER_BORDER_EN draws a white 1-pixel frame around
// the visible area, overriding sprite and background.
module vga_sprite_render
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int SPR_W_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_irq
);

    bank_t       active;
    logic [10:0] h_ext, v_ext, x_end, y_end;
    logic        visible, in_spr;
    logic [2:0]  rgb_reg, rgb_next;
    logic        hsync_reg, vsync_reg;

    wb_vga_regs #(
        .V_ACTIVE  (V_ACTIVE),
        .SPR_W_MAX (SPR_W_MAX)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .active    (active),
        .frame_irq (frame_irq)
    );

    // 11-bit extents: X+W can reach 1023+64 without wrapping back over 0.
    assign h_ext   = {1'b0, hcount};
    assign v_ext   = {1'b0, vcount};
    assign x_end   = {1'b0, active.spr_x} + {4'd0, active.spr_w};
    assign y_end   = {1'b0, active.spr_y} + {4'd0, active.spr_h};
    assign visible = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    // A zero width or height gives an empty range, so no special case.
    assign in_spr  = active.spr_en
                     && (h_ext >= {1'b0, active.spr_x}) && (h_ext < x_end)
                     && (v_ext >= {1'b0, active.spr_y}) && (v_ext < y_end);

`ifdef VGA_RENDER_BORDER_EN
    logic on_border;
    assign on_border = (hcount == 10'd0) || (hcount == 10'(H_ACTIVE - 1))
                    || (vcount == 10'd0) || (vcount == 10'(V_ACTIVE - 1));
`endif

    always_comb begin
        rgb_next = BLACK;
        if (!visible)
            rgb_next = BLACK;
`ifdef VGA_RENDER_BORDER_EN
        else if (on_border)
            rgb_next = WHITE;
`endif
        else if (in_spr)
            rgb_next = active.spr_col;
        else
            rgb_next = active.bg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg   <= BLACK;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else if (pix_en) begin
            rgb_reg   <= rgb_next;
            hsync_reg <= hsync_in;
            vsync_reg <= vsync_in;
        end
    end

    assign red       = rgb_reg[2];
    assign green     = rgb_reg[1];
    assign blue      = rgb_reg[0];
    assign hsync_out = hsync_reg;
    assign vsync_out = vsync_reg;

endmodule

// File: tb/tb_vga_sprite_render.sv
// tb_vga_sprite_render: self-checking bench for vga_sprite_render.
// The bench plays the timing generator over a sparse pixel grid (selected
// lines and columns, including the bank-load point), keeps its own model of
// the pending/active banks, and scoreboards the expected RGB+syncs.
module tb_vga_sprite_render;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int WMAX  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  hcount, vcount;
    logic        hsync_in, vsync_in;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
    logic        red, green, blue, hsync_out, vsync_out, frame_irq;

    always #5 clk = ~clk;

    vga_sprite_render #(
        .H_ACTIVE  (H_ACT),
        .V_ACTIVE  (V_ACT),
        .SPR_W_MAX (WMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .frame_irq (frame_irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending and active banks as plain integers.
    int p_en, p_bg, p_x, p_y, p_w, p_h, p_col;
    int a_en, a_bg, a_x, a_y, a_w, a_h, a_col;
    int m_frames, m_irqs;

    int ack_seen = 0;
    int irq_seen = 0;
    always @(negedge clk) begin
        if (wb_ack_o)  ack_seen++;
        if (frame_irq) irq_seen++;
    end

    typedef struct {
        logic [4:0] val;
        int         h;
        int         v;
    } exp_t;
    exp_t sb[$];

    int lines[13] = '{0, 49, 50, 55, 59, 60, 200, 240, 479, 480, 481, 490, 500};
    int cols[11]  = '{0, 99, 100, 104, 107, 108, 636, 639, 640, 643, 700};

    task automatic model_reset();
        p_en = 0; p_bg = 0; p_x = 0; p_y = 0; p_w = 0; p_h = 0; p_col = 0;
        a_en = 0; a_bg = 0; a_x = 0; a_y = 0; a_w = 0; a_h = 0; a_col = 0;
        m_frames = 0;
    endtask

    function automatic int sat(input int v);
        return (v > WMAX) ? WMAX : v;
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d);
        case (idx)
            0: begin p_en = int'(d[0]); p_bg = int'(d[3:1]); end
            1: p_x = int'(d[9:0]);
            2: p_y = int'(d[9:0]);
            3: begin p_w = sat(int'(d[6:0])); p_h = sat(int'(d[14:8])); p_col = int'(d[18:16]); end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input int idx);
        logic [31:0] r;
        r = 32'd0;
        case (idx)
            0: r = 32'(p_bg * 2 + p_en);
            1: r = 32'(p_x);
            2: r = 32'(p_y);
            3: r = 32'((p_col << 16) | (p_h << 8) | p_w);
            4: r = 32'(m_frames);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] exp_rgb(input int h, input int v);
        if (h >= H_ACT || v >= V_ACT) return 3'b000;
`ifdef VGA_RENDER_BORDER_EN
        if (h == 0 || h == H_ACT - 1 || v == 0 || v == V_ACT - 1) return 3'b111;
`endif
        if (a_en != 0 && h >= a_x && h < a_x + a_w && v >= a_y && v < a_y + a_h)
            return 3'(a_col);
        return 3'(a_bg);
    endfunction

    task automatic pix(input int h, input int v);
        exp_t e;
        @(negedge clk);
        hcount   = 10'(h);
        vcount   = 10'(v);
        hsync_in = !(h >= 656 && h < 752);
        vsync_in = !(v >= 490 && v < 492);
        pix_en   = 1'b1;
        e.val = {exp_rgb(h, v), hsync_in, vsync_in};
        e.h   = h;
        e.v   = v;
        sb.push_back(e);
        if (h == 0 && v == V_ACT) begin
            a_en = p_en; a_bg = p_bg; a_x = p_x; a_y = p_y;
            a_w = p_w; a_h = p_h; a_col = p_col;
            m_frames = (m_frames + 1) & 16'hFFFF;
            m_irqs++;
        end
        @(negedge clk);
        pix_en = 1'b0;
        e = sb.pop_front();
        check($sformatf("pix(%0d,%0d)", e.h, e.v),
              {27'd0, red, green, blue, hsync_out, vsync_out}, {27'd0, e.val});
        repeat (2) @(negedge clk);
    endtask

    task automatic run_lines(input int first, input int last);
        for (int li = first; li <= last; li++)
            for (int ci = 0; ci < 11; ci++)
                pix(cols[ci], lines[li]);
    endtask

    task automatic run_frame(input string name);
        run_lines(0, 12);
        check({name, "_irq_count"}, 32'(irq_seen), 32'(m_irqs));
        $display("frame %s done irqs=%0d", name, irq_seen);
    endtask

    task automatic wb_access(input int idx, input logic we, input logic [31:0] d,
                             output logic [31:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = 5'(idx << 2); wb_dat_i = d;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 10);
        check($sformatf("ack idx%0d", idx), {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        if (we) model_write(idx, d);
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input int idx, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(idx, 1'b1, d, dummy);
        $display("wb write idx=%0d data=0x%08h", idx, d);
    endtask

    task automatic wb_read_check(input int idx);
        logic [31:0] rd, exp;
        exp = model_read(idx);
        wb_access(idx, 1'b0, 32'd0, rd);
        check($sformatf("read idx%0d", idx), rd, exp);
        $display("wb read idx=%0d data=0x%08h", idx, rd);
    endtask

    initial begin
        int acks, b2b;
        logic prev;
        rst = 1'b1; pix_en = 1'b0; hcount = '0; vcount = '0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0;
        model_reset();
        m_irqs = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rgb_sync", {27'd0, red, green, blue, hsync_out, vsync_out}, 32'h3);
        check("reset_ack_irq", {30'd0, wb_ack_o, frame_irq}, 32'd0);
        check("reset_dat_o", wb_dat_o, 32'd0);

        // Frame 1: nothing configured, all black, no Wishbone activity.
        run_frame("black");
        check("ack_idle", 32'(ack_seen), 32'd0);

        // Frame 2: configure mid-frame; this frame must stay black.
        run_lines(0, 6);
        wb_write(0, 32'h5);
        wb_write(1, 32'd100);
        wb_write(2, 32'd50);
        wb_write(3, 32'h0007_0A08);
        run_lines(7, 12);
        check("irq_after_cfg", 32'(irq_seen), 32'(m_irqs));

        // Frame 3: sprite visible at (100..107, 50..59).
        run_frame("sprite");

        // Frame 4: sprite clipped at the right edge.
        wb_write(1, 32'd636);
        run_frame("clip");

        // Register behaviour: saturation, ack spacing, unmapped indices.
        wb_write(3, 32'h0007_0A64);
        wb_read_check(3);
        wb_write(5, 32'hFFFF_FFFF);
        wb_read_check(5);
        wb_read_check(6);
        wb_read_check(4);

        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd0;
        acks = 0; b2b = 0; prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
            if (wb_ack_o && prev) b2b++;
            prev = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("b2b_adjacent_acks", 32'(b2b), 32'd0);
        check("b2b_ack_count", 32'(acks), 32'd4);
        $display("wb burst acks=%0d adjacent=%0d", acks, b2b);
        @(negedge clk);

        // Mid-frame reset at line 200.
        run_lines(0, 5);
        pix(50, 200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rgb_sync", {27'd0, red, green, blue, hsync_out, vsync_out}, 32'h3);
        rst = 1'b0;
        model_reset();
        wb_read_check(4);
        run_frame("post_rst");

`ifdef VGA_RENDER_BORDER_EN
        wb_write(0, 32'h5);
        wb_write(1, 32'd600);
        wb_write(2, 32'd200);
        wb_write(3, 32'h0007_4040);
        run_frame("border_cfg");
        run_frame("border");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
